ysyx_mem_arb: RTL

YSYX_MEM_ARB -- requirements
Module: ysyx_mem_arb
Single-port memory arbiter/sequencer sharing one memory port between instruction fetch (IFU) and load/store (LSU); one outstanding transaction.

---
 rtl/ysyx_mem_pkg.sv | 22 ++
 rtl/ysyx_rr_arb2.sv | 26 ++
 rtl/ysyx_mem_arb.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_mem_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
//   state_t : arbiter FSM states (IDLE, REQ, WAIT, RESP)
//   owner_t : which requester owns the current transaction
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
package ysyx_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_rr_arb2.sv
// Two-way round-robin picker.
//   valid_ifu, valid_lsu : pending requests
//   last_grant           : requester granted most recently
//   grant                : one-hot grant, bit 0 = IFU, bit 1 = LSU
// A lone requester always wins; on a tie the one not granted last wins.
module ysyx_rr_arb2
  import ysyx_mem_pkg::*;
(
  input  logic       valid_ifu,
  input  logic       valid_lsu,
  input  owner_t     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid_ifu && valid_lsu) begin
      grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
    end else if (valid_ifu) begin
      grant = 2'b01;
    end else if (valid_lsu) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_mem_arb.sv
// Single-port memory arbiter/sequencer shared by instruction fetch (IFU)
// and load/store (LSU). One transaction is outstanding at a time.
//   clk, rst                  : clock, synchronous active-high reset
//   ifu_req_* / ifu_rsp_*     : IFU read request / response channel
//   lsu_req_* / lsu_rsp_*     : LSU read/write request / response channel
//   mem_req_* / mem_rsp_*     : downstream memory port
// Parameters: ADDR_W, DATA_W, TIMEOUT (WAIT cycles before error response).
module ysyx_mem_arb
  import ysyx_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  // Counter value seen on the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  owner_t              owner_reg, last_grant_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                wen_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [MASK_W-1:0]   wmask_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                err_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic [1:0]          arb_grant;
  logic [1:0]          grant;
  logic                rsp_hs;
  logic                wait_expired;

  ysyx_rr_arb2 u_rr (
    .valid_ifu  (ifu_req_valid),
    .valid_lsu  (lsu_req_valid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant)
  );

  // Grants are only issued while idle; everywhere else both readies stay low.
  assign grant        = (state_reg == IDLE) ? arb_grant : 2'b00;
  assign rsp_hs       = (owner_reg == OWN_IFU) ? ifu_rsp_ready : lsu_rsp_ready;
  assign wait_expired = (cnt_reg == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (|grant) state_next = REQ;
      REQ:  if (mem_req_ready) state_next = WAIT;
      WAIT: if (mem_rsp_valid || wait_expired) state_next = RESP;
      RESP: if (rsp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ifu_req_ready = grant[0];
    lsu_req_ready = grant[1];
    mem_req_valid = (state_reg == REQ);
    mem_addr      = addr_reg;
    mem_wen       = wen_reg;
    mem_wdata     = wdata_reg;
    mem_wmask     = wmask_reg;
    ifu_rsp_valid = (state_reg == RESP) && (owner_reg == OWN_IFU);
    lsu_rsp_valid = (state_reg == RESP) && (owner_reg == OWN_LSU);
    ifu_rdata     = rdata_reg;
    lsu_rdata     = rdata_reg;
    ifu_rsp_err   = err_reg;
    lsu_rsp_err   = err_reg;
  end

  // Transaction datapath: latched request, response and timeout counter.
  // mem_rsp_valid is only looked at in WAIT, so stray or late responses
  // (including ones arriving after a reset abort) are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg      <= OWN_IFU;
      last_grant_reg <= OWN_LSU;
      addr_reg       <= '0;
      wen_reg        <= 1'b0;
      wdata_reg      <= '0;
      wmask_reg      <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant[0]) begin
            owner_reg      <= OWN_IFU;
            last_grant_reg <= OWN_IFU;
            addr_reg       <= ifu_addr;
            wen_reg        <= 1'b0;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
          end else if (grant[1]) begin
            owner_reg      <= OWN_LSU;
            last_grant_reg <= OWN_LSU;
            addr_reg       <= lsu_addr;
            wen_reg        <= lsu_wen;
            wdata_reg      <= lsu_wdata;
            wmask_reg      <= lsu_wmask;
          end
        end
        REQ: begin
          if (mem_req_ready) cnt_reg <= '0;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            rdata_reg <= mem_rdata;
            err_reg   <= 1'b0;
          end else if (wait_expired) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
